md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO registers for the 5-stage pipeline.
//  Lives in the E stage beside the ALU; takes forwarded operands (MFRSE/MFRTE outputs).
//  Models multi-cycle latency, and exports Busy so the hazard unit stalls on mult/div/mf*/mt*.
//  Generalises the single-cycle ALU datapath: configurable width and latency, and
//  HI/LO state the ALU path lacks.
// PARAMETERS
//  WIDTH        32  operand / HI / LO width (>=2)
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  Clk    in   1      clock, single domain, rising edge
//  Reset  in   1      synchronous, active-high
//  Start  in   1      E-stage instr is an md op; sampled with Mdop/A/B at the edge
//  Mdop   in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//  A      in   WIDTH  rs operand (dividend / multiplicand / mt* source)
//  B      in   WIDTH  rt operand (divisor / multiplier)
//  Busy   out  1      operation in flight; registered
//  Done   out  1      one-cycle pulse in the cycle HI/LO first show a mult/div result
//  Hi     out  WIDTH  HI register (mfhi source)
//  Lo     out  WIDTH  LO register (mflo source)
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-operation): Busy=0, Done=0, Hi=0, Lo=0, counter=0.
//    Pending result is discarded. Reset beats Start in the same cycle.
//  - Idle + Start + Mdop in 0..3 at edge t:
//    - Result is computed from A/B sampled at t and held in pending regs.
//    - Busy=1 from t+1 for N cycles (N=MULT_CYCLES or DIV_CYCLES).
//    - Counter loads N-1 and decrements once per cycle.
//    - On the edge where counter==0 and Busy: Hi/Lo <= pending, Busy <= 0, Done <= 1.
//    - Result is visible at t+N+1. Busy is low in that same cycle.
//  - Idle + Start + MTHI/MTLO: Hi (resp. Lo) <= A at the next edge. Busy and Done stay 0.
//  - Idle + Start + Mdop 6-7: no state change.
//  - Start while Busy: ignored entirely; operands are not latched and the counter is not
//    reloaded. The hazard unit must prevent this. The bench checks that it is harmless.
//  - Arithmetic:
//    - MULT: signed WIDTHxWIDTH -> 2*WIDTH. MULTU: unsigned. Hi=upper half, Lo=lower half.
//    - DIV/DIVU: Lo=quotient, Hi=remainder.
//      - Signed quotient truncates toward zero; remainder takes the dividend's sign.
//    - Divide by zero (B==0): Lo=all ones, Hi=A, for both signed and unsigned.
//    - Signed overflow (A=min_neg, B=-1): Lo=A, Hi=0.
//  - Hi/Lo change only at completion, at mt*, or at reset. They are stable while Busy.
//  - Stall contract for the hazard unit: stall D when an md/mf*/mt* op is in D and
//    (Start|Busy).
// STRUCTURE
//  - Shared package/header: Mdop encodings (MD_MULT..MD_MTLO) as localparams/`defines.
//    The same constants are used by the controller and the hazard unit.
//  - Control: idle/busy FSM (Busy flag + down-counter).
//    - Counter width = $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//    - Pending hi/lo result registers.
//  - Sub-module md_calc (combinational):
//    - Inputs: A, B, Mdop. Outputs: res_hi, res_lo.
//    - Holds all sign handling and the div-by-zero / overflow rules.
// TESTING (WIDTH=32, defaults)
//  1. MULT A=FFFFFFFD (-3), B=5 -> Busy high 5 cycles; then Hi=FFFFFFFF, Lo=FFFFFFF1, Done pulse.
//  2. MULTU A=FFFFFFFF, B=2 -> after 5 cycles Hi=00000001, Lo=FFFFFFFE.
//  3. DIV A=FFFFFFF9 (-7), B=2 -> Busy 10 cycles; then Lo=FFFFFFFD, Hi=FFFFFFFF.
//     DIVU A=7, B=0 -> Lo=FFFFFFFF, Hi=00000007.
//  4. MULT 3*4, then at busy cycle 2 Start DIV 9/3 -> ignored.
//     Hi=0, Lo=0000000C after 5 cycles; Busy drops on schedule.
//  5. DIV started, Reset at busy cycle 4 -> next cycle Busy=0, Hi=Lo=0, no Done.
//     A later MTLO A=12345678 -> Lo=12345678 one edge later, Busy stays 0.
//  6. Sweep MULT_CYCLES=1, DIV_CYCLES=1 -> Busy high exactly 1 cycle.
//     Random A/B vs reference model, 1000 ops.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide opcode encodings and small decode helpers.
// The controller, md_calc and the hazard unit all use these constants.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // True for the multi-cycle operations that produce a HI/LO result.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the multiply flavours (selects the multiply latency).
  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_calc.sv
// md_calc: combinational HI/LO result for MULT/MULTU/DIV/DIVU.
// All sign handling and the divide-by-zero / signed-overflow rules live here,
// so the controller only has to decide when the result is committed.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Mdop,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      a_neg, b_neg, b_zero, s_ovf;
  logic        [WIDTH-1:0]   a_mag, b_mag, b_safe, bu_safe;
  logic        [WIDTH-1:0]   q_mag, r_mag, q_s, r_s;

  // Full-width products: signed via explicit sign extension, unsigned via zero extension.
  assign prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed divide works on magnitudes so truncation toward zero is explicit;
  // divisors are forced non-zero so the dividers never see a zero operand.
  assign a_neg   = A[WIDTH-1];
  assign b_neg   = B[WIDTH-1];
  assign b_zero  = (B == '0);
  assign s_ovf   = (A == MIN_NEG) && (B == ALL_ONE);
  assign a_mag   = a_neg ? (~A + ONE) : A;
  assign b_mag   = b_neg ? (~B + ONE) : B;
  assign b_safe  = b_zero ? ONE : b_mag;
  assign bu_safe = b_zero ? ONE : B;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign q_s     = (a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag;
  assign r_s     = a_neg ? (~r_mag + ONE) : r_mag;

  // Select the result for the requested operation, applying the special cases.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (Mdop)
      MD_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MD_DIV: begin
        if (b_zero) begin
          res_hi = A;
          res_lo = ALL_ONE;
        end else if (s_ovf) begin
          res_hi = '0;
          res_lo = A;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          res_hi = A;
          res_lo = ALL_ONE;
        end else begin
          res_hi = A % bu_safe;
          res_lo = A / bu_safe;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO registers.
// An idle/busy FSM with a down-counter models the multi-cycle latency; the
// result is computed at issue, parked in pending registers and committed to
// HI/LO when the counter expires. Busy is the FSM state itself.
// Handshake: Start is a one-cycle request qualified only while idle; a Start
// seen while Busy is dropped without latching anything (the hazard unit must
// hold md/mf*/mt* ops in D while Start|Busy). Done pulses for one cycle when
// HI/LO first show a mult/div result.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Mdop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] calc_hi, calc_lo;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .A      (A),
    .B      (B),
    .Mdop   (Mdop),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  // Next-state: issue from idle, count down while busy, commit on expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (md_is_arith(Mdop)) begin
            state_d   = ST_BUSY;
            cnt_d     = md_is_mul(Mdop) ? MULT_LOAD : DIV_LOAD;
            pend_hi_d = calc_hi;
            pend_lo_d = calc_lo;
          end else if (Mdop == MD_MTHI) begin
            hi_d = A;
          end else if (Mdop == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // State registers; reset clears everything and discards any pending result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q == ST_BUSY);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: default-latency instance for directed scenarios and a
// single-cycle-latency instance for a random sweep against a reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start, start_f;
  logic [2:0]  mdop, mdop_f;
  logic [31:0] a, b, a_f, b_f;
  logic        busy, done, busy_f, done_f;
  logic [31:0] hi, lo, hi_f, lo_f;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_hi, exp_lo, exp_hi_f, exp_lo_f;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Mdop(mdop), .A(a), .B(b),
    .Busy(busy), .Done(done), .Hi(hi), .Lo(lo)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_f (
    .Clk(clk), .Reset(rst), .Start(start_f), .Mdop(mdop_f), .A(a_f), .B(b_f),
    .Busy(busy_f), .Done(done_f), .Hi(hi_f), .Lo(lo_f)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one Start on the main instance, return in the cycle after the edge.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; mdop = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; mdop = 3'd7; a = '0; b = '0;
  endtask

  // Reference model for mult/div results.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    rh = '0; rl = '0;
    case (op)
      MD_MULT:  begin p = sa * sb; {rh, rl} = p; end
      MD_MULTU: begin pu = {32'b0, av} * {32'b0, bv}; {rh, rl} = pu; end
      MD_DIV: begin
        if (bv == 0) begin rl = 32'hFFFF_FFFF; rh = av; end
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      MD_DIVU: begin
        if (bv == 0) begin rl = 32'hFFFF_FFFF; rh = av; end
        else begin rl = av / bv; rh = av % bv; end
      end
      default: begin rh = '0; rl = '0; end
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_hi_f = '0; exp_lo_f = '0;
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    n_vec++;
    if ({busy_f, done_f, hi_f, lo_f} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_fast: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy_f, done_f, hi_f, lo_f);
    end
  endtask

  // Table-driven mult/div vectors: Busy for exactly N cycles, HI/LO stable, then Done and result.
  task automatic test_arith();
    logic [2:0]  t_op [6];
    logic [31:0] t_a [6], t_b [6], t_hi [6], t_lo [6];
    int          t_n [6];
    t_op[0] = MD_MULT;  t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd5; t_hi[0] = 32'hFFFF_FFFF; t_lo[0] = 32'hFFFF_FFF1; t_n[0] = 5;
    t_op[1] = MD_MULTU; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'd2; t_hi[1] = 32'h0000_0001; t_lo[1] = 32'hFFFF_FFFE; t_n[1] = 5;
    t_op[2] = MD_DIV;   t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2; t_hi[2] = 32'hFFFF_FFFF; t_lo[2] = 32'hFFFF_FFFD; t_n[2] = 10;
    t_op[3] = MD_DIVU;  t_a[3] = 32'd7;         t_b[3] = 32'd0; t_hi[3] = 32'h0000_0007; t_lo[3] = 32'hFFFF_FFFF; t_n[3] = 10;
    t_op[4] = MD_DIV;   t_a[4] = 32'h8000_0000; t_b[4] = 32'hFFFF_FFFF; t_hi[4] = 32'h0; t_lo[4] = 32'h8000_0000; t_n[4] = 10;
    t_op[5] = MD_DIV;   t_a[5] = 32'hFFFF_FFF9; t_b[5] = 32'd0; t_hi[5] = 32'hFFFF_FFF9; t_lo[5] = 32'hFFFF_FFFF; t_n[5] = 10;
    for (int v = 0; v < 6; v++) begin
      drive_op(t_op[v], t_a[v], t_b[v]);
      for (int k = 1; k <= t_n[v]; k++) begin
        n_vec++;
        if ({busy, done, hi, lo} !== {1'b1, 1'b0, exp_hi, exp_lo}) begin
          n_err++;
          $display("FAIL arith%0d_busy_c%0d: busy=%b done=%b hi=%h lo=%h, required 1 0 %h %h",
                   v, k, busy, done, hi, lo, exp_hi, exp_lo);
        end
        @(negedge clk);
      end
      exp_hi = t_hi[v]; exp_lo = t_lo[v];
      n_vec++;
      if ({busy, done, hi, lo} !== {1'b0, 1'b1, exp_hi, exp_lo}) begin
        n_err++;
        $display("FAIL arith%0d_result: busy=%b done=%b hi=%h lo=%h, required 0 1 %h %h",
                 v, busy, done, hi, lo, exp_hi, exp_lo);
      end
      @(negedge clk);
      n_vec++;
      if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
        n_err++;
        $display("FAIL arith%0d_after: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h",
                 v, busy, done, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  // Start during Busy must be ignored: no reload, no operand capture.
  task automatic test_back_to_back();
    drive_op(MD_MULT, 32'd3, 32'd4);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin
        start = 1'b1; mdop = MD_DIV; a = 32'd9; b = 32'd3;
      end
      n_vec++;
      if ({busy, done, hi, lo} !== {1'b1, 1'b0, exp_hi, exp_lo}) begin
        n_err++;
        $display("FAIL b2b_busy_c%0d: busy=%b done=%b hi=%h lo=%h, required 1 0 %h %h",
                 k, busy, done, hi, lo, exp_hi, exp_lo);
      end
      @(negedge clk);
      start = 1'b0; mdop = 3'd7; a = '0; b = '0;
    end
    exp_hi = 32'h0; exp_lo = 32'h0000_000C;
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b1, exp_hi, exp_lo}) begin
      n_err++;
      $display("FAIL b2b_result: busy=%b done=%b hi=%h lo=%h, required 0 1 %h %h", busy, done, hi, lo, exp_hi, exp_lo);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
        n_err++;
        $display("FAIL b2b_quiet_c%0d: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h",
                 k, busy, done, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  // Reset mid-divide discards the result; then mt*, no-op and reset-beats-start.
  task automatic test_reset_mid_and_mt();
    drive_op(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_hi_f = '0; exp_lo_f = '0;
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL midreset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
        n_err++;
        $display("FAIL midreset_quiet_c%0d: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", k, busy, done, hi, lo);
      end
    end
    drive_op(MD_MTLO, 32'h1234_5678, 32'hDEAD_BEEF);
    exp_lo = 32'h1234_5678;
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
      n_err++;
      $display("FAIL mtlo: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h", busy, done, hi, lo, exp_hi, exp_lo);
    end
    drive_op(MD_MTHI, 32'hABCD_EF01, 32'h0);
    exp_hi = 32'hABCD_EF01;
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
      n_err++;
      $display("FAIL mthi: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h", busy, done, hi, lo, exp_hi, exp_lo);
    end
    drive_op(3'd6, 32'h5555_5555, 32'h3);
    @(negedge clk);
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
      n_err++;
      $display("FAIL noop: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h", busy, done, hi, lo, exp_hi, exp_lo);
    end
    rst = 1'b1;
    drive_op(MD_MULT, 32'd6, 32'd7);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    n_vec++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_beats_start: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_beats_start_next: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // Single-cycle latency instance: random operands against the reference model.
  task automatic test_fast_random();
    logic [2:0]  op;
    logic [31:0] av, bv, rh, rl;
    int          sel;
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 3));
      av = $urandom; bv = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) bv = 32'h0;
      else if (sel == 1) begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
      else if (sel == 2) bv = 32'h1;
      else if (sel == 3) bv = 32'($urandom_range(1, 9));
      ref_md(op, av, bv, rh, rl);
      start_f = 1'b1; mdop_f = op; a_f = av; b_f = bv;
      @(negedge clk);
      start_f = 1'b0; mdop_f = 3'd7; a_f = '0; b_f = '0;
      n_vec++;
      if ({busy_f, done_f, hi_f, lo_f} !== {1'b1, 1'b0, exp_hi_f, exp_lo_f}) begin
        n_err++;
        $display("FAIL fast%0d_busy: busy=%b done=%b hi=%h lo=%h, required 1 0 %h %h",
                 i, busy_f, done_f, hi_f, lo_f, exp_hi_f, exp_lo_f);
      end
      @(negedge clk);
      exp_hi_f = rh; exp_lo_f = rl;
      n_vec++;
      if ({busy_f, done_f, hi_f, lo_f} !== {1'b0, 1'b1, exp_hi_f, exp_lo_f}) begin
        n_err++;
        $display("FAIL fast%0d_result op=%0d a=%h b=%h: busy=%b done=%b hi=%h lo=%h, required 0 1 %h %h",
                 i, op, av, bv, busy_f, done_f, hi_f, lo_f, exp_hi_f, exp_lo_f);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; mdop = 3'd7; a = '0; b = '0;
    start_f = 1'b0; mdop_f = 3'd7; a_f = '0; b_f = '0;
    exp_hi = '0; exp_lo = '0; exp_hi_f = '0; exp_lo_f = '0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid_and_mt();
    test_fast_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
